mix_cols_iter: RTL and testbench
================================

// Module: mix_cols_iter
// PURPOSE
// - Forward AES MixColumns over a full 128-bit state; the encrypt-side counterpart of reverse_mix_cols.
// - Iterative: COLS_PER_CYCLE columns are processed per clock through a shared combinational column mixer.
// - Sits between ShiftRows and AddRoundKey in the encrypt round datapath.
// - Uses a valid/ready handshake on both input and output.
// PARAMETERS
// - COLS_PER_CYCLE   1   columns mixed per clock; legal values 1, 2, 4; compute latency = 4/COLS_PER_CYCLE
// PORTS
// - clk        input   1    single clock, all state updates on posedge
// - reset      input   1    synchronous, active-high; sampled on posedge clk
// - in_valid   input   1    in_state is valid this cycle
// - in_ready   output  1    block can accept a state (high only in IDLE)
// - in_state   input   128  [127:96]=col0 ... [31:0]=col3; within a column [31:24]=row0 ... [7:0]=row3
// - out_valid  output  1    out_state holds a finished MixColumns result
// - out_ready  input   1    downstream accepts out_state this cycle
// - out_state  output  128  result, same byte layout as in_state
// BEHAVIOUR
// - Reset values: out_valid=0, out_state=128'h0, column counter=0, FSM=IDLE, so in_ready=1 in the first cycle after reset.
// - FSM states:
//   - IDLE: in_ready=1. If in_valid, load in_state into the work register at posedge, then -> RUN with col=0.
//   - RUN: in_ready=0. Each posedge replaces columns col .. col+COLS_PER_CYCLE-1 (col0 first) with their mixed value, and col += COLS_PER_CYCLE.
//     When the last group is written -> HOLD.
//   - HOLD: out_valid=1. If out_ready at posedge -> IDLE and out_valid=0 next cycle.
// - Latency: accept edge to out_valid high = 4/COLS_PER_CYCLE clocks (1 -> 4 clocks, 4 -> 1 clock).
// - Throughput: no same-cycle accept while HOLD is being drained, so the next accept is one cycle after the output handshake.
// - Backpressure: while out_valid=1 and out_ready=0, out_state and out_valid hold stable indefinitely.
// - in_valid outside IDLE is ignored. The data is not captured and no state changes.
// - out_ready outside HOLD is ignored.
// - out_state is the work register. It is only meaningful while out_valid=1; intermediate values are visible during RUN.
// - reset asserted in any state (including mid-RUN or HOLD) discards the work in progress and restores the reset values at that edge.
//   reset wins over a simultaneous in_valid or out_ready.
// - Column arithmetic is GF(2^8) with polynomial 0x11b:
//   - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00)
//   - r0' = 2a0^3a1^a2^a3
//   - r1' = a0^2a1^3a2^a3
//   - r2' = a0^a1^2a2^3a3
//   - r3' = 3a0^a1^a2^2a3
//   - 2x = xtime(x); 3x = xtime(x)^x; all XOR, 8-bit, no carries.
// - Column counter is 2 bits and wraps to 0 on entering HOLD.
// - Illegal COLS_PER_CYCLE values are a compile-time error (generate-time $error).
// STRUCTURE
// - Shared package aes_pkg:
//   - GF_POLY = 8'h1b
//   - xtime function
//   - FSM state enum {IDLE, RUN, HOLD}
//   - AES_NB = 4 columns
// - Sub-module mix_single_col: combinational 32-bit column in -> 32-bit mixed column out.
//   mix_cols_iter instantiates COLS_PER_CYCLE copies via generate.
// - Top holds the FSM, column counter, 128-bit work register and handshake logic.
// TESTING
// - Single column: in_state = {db135345, f20a225c, 01010101, c6c6c6c6}
//   -> out_state = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}.
//   out_valid rises exactly 4 clocks after the accept edge (COLS_PER_CYCLE=1).
// - Second vector: {d4d4d4d5, 2d26314c, 00000000, ffffffff}
//   -> {d5d5d7d6, 4d7ebdf8, 00000000, ffffffff}.
//   Rerun with COLS_PER_CYCLE=4: same result, out_valid 1 clock after accept.
// - Backpressure: hold out_ready=0 for 10 clocks in HOLD -> out_valid stays 1 and out_state is unchanged.
//   Raising out_ready -> out_valid=0 and in_ready=1 on the next cycle.
// - Busy ignore: drive in_valid=1 with a different state during RUN and HOLD
//   -> result still equals the first vector and in_ready stays 0.
// - Reset mid-op: assert reset on the 2nd RUN clock -> next cycle out_valid=0, out_state=0, in_ready=1.
//   A fresh vector then completes correctly.
// - Back-to-back: two vectors, out_ready tied 1 -> both results correct.
//   The second accept occurs one cycle after the first output handshake.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constants, xtime, and the MixColumns FSM state type.
package aes_pkg;

  localparam int       AES_NB  = 4;
  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_col.sv
// Combinational forward MixColumns of one 32-bit column (row0 in bits [31:24]).
module mix_single_col
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign d0 = xtime(a0);
  assign d1 = xtime(a1);
  assign d2 = xtime(a2);
  assign d3 = xtime(a3);

  // 3x is expressed as 2x ^ x
  assign col_out[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
  assign col_out[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/mix_cols_iter.sv
// Iterative forward MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
//   state | meaning
//   IDLE  | in_ready=1, waiting for a state to load
//   RUN   | mixing column groups in place, col0 first
//   HOLD  | out_valid=1, result held until out_ready
module mix_cols_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST_COL = 2'(AES_NB - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % AES_NB);

  state_t      state, state_nxt;
  logic [1:0]  col;
  logic [31:0] work    [AES_NB];
  logic [31:0] mix_in  [COLS_PER_CYCLE];
  logic [31:0] mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    logic [1:0] idx;
    assign idx       = col + 2'(g);
    assign mix_in[g] = work[idx];
    mix_single_col u_mix (
      .col_in  (mix_in[g]),
      .col_out (mix_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (col == LAST_COL) state_nxt = HOLD;
      HOLD:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  // Work register doubles as the output register; mixed columns overwrite in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= 2'd0;
      for (int c = 0; c < AES_NB; c++) work[c] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            col <= 2'd0;
            for (int c = 0; c < AES_NB; c++) work[c] <= in_state[127 - 32*c -: 32];
          end
        end
        RUN: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) work[col + 2'(g)] <= mix_out[g];
          col <= (col == LAST_COL) ? 2'd0 : col + COL_STEP;
        end
        default: ;
      endcase
    end
  end

  assign out_state = {work[0], work[1], work[2], work[3]};

endmodule

// File: tb/tb_mix_cols_iter.sv
// Self-checking bench for mix_cols_iter at COLS_PER_CYCLE=1 and 4 against a GF(2^8) matrix model.
module tb_mix_cols_iter;

  logic         clk, reset;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_state1, out_state1;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] in_state4, out_state4;

  int checks   = 0;
  int failures = 0;

  mix_cols_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_state(out_state1)
  );

  mix_cols_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply, then the MixColumns circulant matrix [2 3 1 1].
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h0;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 1) ? out_valid1 : out_valid4;
  endfunction

  function automatic logic [127:0] get_os(input int w);
    return (w == 1) ? out_state1 : out_state4;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [127:0] s);
    if (w == 1) begin in_valid1 = v; in_state1 = s; end
    else        begin in_valid4 = v; in_state4 = s; end
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 1) out_ready1 = v; else out_ready4 = v;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents v for one accept edge, then counts clocks until out_valid (-1 on timeout).
  task automatic start_op(input int w, input logic [127:0] v, output int lat);
    set_in(w, 1'b1, v);
    step();
    set_in(w, 1'b0, v);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (get_ov(w)) begin lat = k; break; end
    end
  endtask

  task automatic drain(input int w);
    set_or(w, 1'b1);
    step();
    set_or(w, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1 got=%b exp=0", out_valid1); end
    checks++; if (out_state1 !== 128'h0) begin failures++; $display("FAIL reset_out_state1 got=%h exp=0", out_state1); end
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready1 got=%b exp=1", in_ready1); end
    checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_dut4 got ov=%b ir=%b exp ov=0 ir=1", out_valid4, in_ready4); end
    reset = 1'b0;
    step();
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready1); end
  endtask

  task automatic test_single_col();
    logic [127:0] v;
    int lat;
    v = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    start_op(1, v, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL vec1_latency got=%0d exp=4", lat); end
    checks++; if (out_state1 !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin failures++; $display("FAIL vec1_known got=%h exp=8e4da1bc9fdc589d01010101c6c6c6c6", out_state1); end
    checks++; if (out_state1 !== model(v)) begin failures++; $display("FAIL vec1_model got=%h exp=%h", out_state1, model(v)); end
    drain(1);
  endtask

  task automatic test_second_vec();
    logic [127:0] v;
    logic [127:0] known;
    int lat;
    v     = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    known = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    start_op(1, v, lat);
    checks++; if (lat != 4 || out_state1 !== known) begin failures++; $display("FAIL vec2_c1 got lat=%0d %h exp lat=4 %h", lat, out_state1, known); end
    drain(1);
    start_op(4, v, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL vec2_c4_latency got=%0d exp=1", lat); end
    checks++; if (out_state4 !== known) begin failures++; $display("FAIL vec2_c4_data got=%h exp=%h", out_state4, known); end
    drain(4);
  endtask

  task automatic test_backpressure();
    logic [127:0] v, exp;
    int lat;
    v = rand128();
    exp = model(v);
    start_op(1, v, lat);
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (out_valid1 !== 1'b1 || out_state1 !== exp) begin failures++; $display("FAIL bp_hold cyc=%0d got ov=%b %h exp ov=1 %h", k, out_valid1, out_state1, exp); end
    end
    drain(1);
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid1, in_ready1); end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] a, b;
    int lat;
    a = rand128();
    b = ~a;
    set_in(1, 1'b1, a);
    step();
    set_in(1, 1'b1, b);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL busy_in_ready_run k=%0d got=%b exp=0", k, in_ready1); end
      step();
      if (out_valid1) begin lat = k; break; end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL busy_in_ready_hold k=%0d got=%b exp=0", k, in_ready1); end
    end
    set_in(1, 1'b0, b);
    checks++; if (lat != 4 || out_state1 !== model(a)) begin failures++; $display("FAIL busy_result got lat=%0d %h exp lat=4 %h", lat, out_state1, model(a)); end
    drain(1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    int lat;
    v = rand128();
    set_in(1, 1'b1, v);
    step();
    set_in(1, 1'b0, v);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || out_state1 !== 128'h0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_mid got ov=%b ir=%b %h exp ov=0 ir=1 0", out_valid1, in_ready1, out_state1); end
    v = rand128();
    start_op(1, v, lat);
    checks++; if (lat != 4 || out_state1 !== model(v)) begin failures++; $display("FAIL reset_mid_fresh got lat=%0d %h exp lat=4 %h", lat, out_state1, model(v)); end
    drain(1);
  endtask

  task automatic test_random();
    logic [127:0] v;
    int lat, w, explat;
    for (int i = 0; i < 12; i++) begin
      w = (i % 2 == 0) ? 1 : 4;
      explat = (w == 1) ? 4 : 1;
      v = rand128();
      start_op(w, v, lat);
      repeat ($urandom_range(0, 3)) step();
      checks++; if (lat != explat || get_ov(w) !== 1'b1 || get_os(w) !== model(v)) begin
        failures++; $display("FAIL random i=%0d w=%0d got lat=%0d %h exp lat=%0d %h", i, w, lat, get_os(w), explat, model(v));
      end
      drain(w);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [2];
    int acc_cyc [2];
    int hs_cyc  [2];
    int n_in, n_out;
    logic take_in, take_out;
    vec[0] = rand128();
    vec[1] = rand128();
    n_in = 0; n_out = 0;
    acc_cyc[0] = -9; acc_cyc[1] = -9; hs_cyc[0] = -9; hs_cyc[1] = -9;
    out_ready1 = 1'b1;
    set_in(1, 1'b1, vec[0]);
    for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
      take_in  = in_valid1 && in_ready1;
      take_out = out_valid1 && out_ready1;
      if (take_out) begin
        checks++; if (out_state1 !== model(vec[n_out])) begin failures++; $display("FAIL b2b_data n=%0d got=%h exp=%h", n_out, out_state1, model(vec[n_out])); end
        hs_cyc[n_out] = cyc;
        n_out++;
      end
      step();
      if (take_in) begin
        acc_cyc[n_in] = cyc;
        n_in++;
        if (n_in < 2) set_in(1, 1'b1, vec[1]);
        else          set_in(1, 1'b0, vec[1]);
      end
    end
    out_ready1 = 1'b0;
    set_in(1, 1'b0, vec[1]);
    checks++; if (n_out != 2) begin failures++; $display("FAIL b2b_timeout got=%0d results exp=2", n_out); end
    checks++; if (acc_cyc[1] != hs_cyc[0] + 1) begin failures++; $display("FAIL b2b_accept_gap got accept=%0d exp=%0d", acc_cyc[1], hs_cyc[0] + 1); end
    step();
  endtask

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0; in_state1 = '0; out_ready1 = 1'b0;
    in_valid4 = 1'b0; in_state4 = '0; out_ready4 = 1'b0;
    test_reset();
    test_single_col();
    test_second_vec();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
